// File: rtl/ise_pkg.sv
// Shared types for the image sorting engine: colour classes, FSM states,
// the sort-entry record and the ordering rule used by the sort buffer.
package ise_pkg;

   localparam int KEY_MAX_W = 32;
   localparam int IDX_MAX_W = 16;

   typedef enum logic [1:0] {
      COL_R = 2'd0,
      COL_G = 2'd1,
      COL_B = 2'd2
   } color_e;

   typedef enum logic [1:0] {
      ST_ACCEPT = 2'd0,
      ST_FINAL  = 2'd1,
      ST_INSERT = 2'd2,
      ST_OUTPUT = 2'd3
   } state_e;

   typedef struct packed {
      color_e                 cls;
      logic [KEY_MAX_W-1:0]   key;
      logic [IDX_MAX_W-1:0]   idx;
   } sort_entry_t;

   // True when a must be placed strictly ahead of b: class ascending,
   // then key descending, then index ascending.
   function automatic logic entry_before(input sort_entry_t a, input sort_entry_t b);
      logic res;
      if (a.cls != b.cls) begin
         res = (a.cls < b.cls);
      end else if (a.key != b.key) begin
         res = (a.key > b.key);
      end else begin
         res = (a.idx < b.idx);
      end
      return res;
   endfunction

endpackage

// File: rtl/ise_sort_buf.sv
// Insertion-sorted buffer: parallel-compare insert of one entry, shift-up pop,
// and a look-ahead head so the consumer can register the next head value.
module ise_sort_buf
   import ise_pkg::*;
#(
   parameter int DEPTH   = 32,
   parameter int KEY_W   = 15,
   parameter int IDX_W   = 5,
   parameter int COUNT_W = $clog2(DEPTH + 1)
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               ins,
   input  color_e             ins_cls,
   input  logic [KEY_W-1:0]   ins_key,
   input  logic [IDX_W-1:0]   ins_idx,
   input  logic               pop,
   output logic [COUNT_W-1:0] count,
   output color_e             head_nxt_cls,
   output logic [KEY_W-1:0]   head_nxt_key,
   output logic [IDX_W-1:0]   head_nxt_idx
);

   typedef struct packed {
      color_e             cls;
      logic [KEY_W-1:0]   key;
      logic [IDX_W-1:0]   idx;
   } slot_t;

   slot_t              slots     [DEPTH];
   slot_t              slots_nxt [DEPTH];
   slot_t              new_slot;
   logic [DEPTH-1:0]   ahead;
   logic [COUNT_W-1:0] count_nxt;

   function automatic sort_entry_t widen(input slot_t s);
      sort_entry_t e;
      e.cls = s.cls;
      e.key = KEY_MAX_W'(s.key);
      e.idx = IDX_MAX_W'(s.idx);
      return e;
   endfunction

   assign new_slot = {ins_cls, ins_key, ins_idx};

   // Equal entries stay ahead of the newcomer, keeping arrival order stable.
   always_comb begin
      ahead = '0;
      for (int i = 0; i < DEPTH; i++) begin
         ahead[i] = (COUNT_W'(i) < count) && !entry_before(widen(new_slot), widen(slots[i]));
      end
   end

   always_comb begin
      slots_nxt = slots;
      if (ins) begin
         slots_nxt[0] = ahead[0] ? slots[0] : new_slot;
         for (int i = 1; i < DEPTH; i++) begin
            if (ahead[i]) begin
               slots_nxt[i] = slots[i];
            end else if (ahead[i-1]) begin
               slots_nxt[i] = new_slot;
            end else begin
               slots_nxt[i] = slots[i-1];
            end
         end
      end else if (pop) begin
         for (int i = 0; i < DEPTH - 1; i++) begin
            slots_nxt[i] = slots[i+1];
         end
         slots_nxt[DEPTH-1] = '0;
      end else begin
         slots_nxt = slots;
      end
   end

   always_comb begin
      if (ins && !pop) begin
         count_nxt = count + COUNT_W'(1);
      end else if (pop && !ins) begin
         count_nxt = count - COUNT_W'(1);
      end else begin
         count_nxt = count;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         count <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            slots[i] <= '0;
         end
      end else begin
         count <= count_nxt;
         for (int i = 0; i < DEPTH; i++) begin
            slots[i] <= slots_nxt[i];
         end
      end
   end

   assign head_nxt_cls = slots_nxt[0].cls;
   assign head_nxt_key = slots_nxt[0].key;
   assign head_nxt_idx = slots_nxt[0].idx;

endmodule

// File: rtl/ise_sort_param.sv
// Parametrised image sorting engine: classifies each streamed image by its
// dominant colour, insertion-sorts a batch and streams it out in order.
module ise_sort_param
   import ise_pkg::*;
#(
   parameter int IMAGE_NUM  = 32,
   parameter int IMAGE_SIZE = 128,
   parameter int CH_W       = 8,
   parameter int IDX_W      = $clog2(IMAGE_NUM),
   parameter int CNT_W      = $clog2(IMAGE_SIZE * IMAGE_SIZE + 1)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   input  logic [IDX_W-1:0]  image_in_index,
   input  logic [3*CH_W-1:0] pixel_in,
   output logic              busy,
   output logic              out_valid,
   output logic [1:0]        color_index,
   output logic [IDX_W-1:0]  image_out_index,
   output logic [CNT_W-1:0]  dom_count
);

   localparam int PIX_N  = IMAGE_SIZE * IMAGE_SIZE;
   localparam int BUF_CW = $clog2(IMAGE_NUM + 1);
   localparam logic [CNT_W-1:0]  PIX_LAST = CNT_W'(PIX_N - 1);
   localparam logic [BUF_CW-1:0] BUF_LAST = BUF_CW'(IMAGE_NUM - 1);
   localparam logic [BUF_CW-1:0] BUF_ONE  = BUF_CW'(1);

   state_e             state, state_nxt;
   logic [CNT_W-1:0]   pix_cnt, cnt_r, cnt_g, cnt_b;
   logic [IDX_W-1:0]   img_idx;
   color_e             pend_cls, px_cls, fin_cls;
   logic [CNT_W-1:0]   pend_key, fin_key;
   logic               accept, last_pix, do_final, do_insert, do_pop;
   logic [CH_W-1:0]    ch_r, ch_g, ch_b;
   logic [BUF_CW-1:0]  buf_count;
   color_e             head_nxt_cls;
   logic [CNT_W-1:0]   head_nxt_key;
   logic [IDX_W-1:0]   head_nxt_idx;

   assign ch_r     = pixel_in[3*CH_W-1:2*CH_W];
   assign ch_g     = pixel_in[2*CH_W-1:CH_W];
   assign ch_b     = pixel_in[CH_W-1:0];
   assign last_pix = accept && (pix_cnt == PIX_LAST);

   // Pixel class: largest channel, ties favour R then G.
   always_comb begin
      if ((ch_r >= ch_g) && (ch_r >= ch_b)) begin
         px_cls = COL_R;
      end else if (ch_g >= ch_b) begin
         px_cls = COL_G;
      end else begin
         px_cls = COL_B;
      end
   end

   // Image class: largest counter, same tie order; key is the winning count.
   always_comb begin
      if ((cnt_r >= cnt_g) && (cnt_r >= cnt_b)) begin
         fin_cls = COL_R;
         fin_key = cnt_r;
      end else if (cnt_g >= cnt_b) begin
         fin_cls = COL_G;
         fin_key = cnt_g;
      end else begin
         fin_cls = COL_B;
         fin_key = cnt_b;
      end
   end

   // FSM state register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= ST_ACCEPT;
      end else begin
         state <= state_nxt;
      end
   end

   // FSM next-state logic.
   always_comb begin
      state_nxt = state;
      case (state)
         ST_ACCEPT: state_nxt = last_pix ? ST_FINAL : ST_ACCEPT;
         ST_FINAL:  state_nxt = ST_INSERT;
         ST_INSERT: state_nxt = (buf_count == BUF_LAST) ? ST_OUTPUT : ST_ACCEPT;
         ST_OUTPUT: state_nxt = (buf_count == BUF_ONE) ? ST_ACCEPT : ST_OUTPUT;
         default:   state_nxt = ST_ACCEPT;
      endcase
   end

   // FSM control decode.
   always_comb begin
      accept    = 1'b0;
      do_final  = 1'b0;
      do_insert = 1'b0;
      do_pop    = 1'b0;
      case (state)
         ST_ACCEPT: accept    = in_valid;
         ST_FINAL:  do_final  = 1'b1;
         ST_INSERT: do_insert = 1'b1;
         ST_OUTPUT: do_pop    = 1'b1;
         default:   accept    = 1'b0;
      endcase
   end

   // Per-image pixel counting, index latch and end-of-image classification.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pix_cnt  <= '0;
         cnt_r    <= '0;
         cnt_g    <= '0;
         cnt_b    <= '0;
         img_idx  <= '0;
         pend_cls <= COL_R;
         pend_key <= '0;
      end else if (accept) begin
         pix_cnt <= last_pix ? '0 : (pix_cnt + CNT_W'(1));
         if (pix_cnt == '0) begin
            img_idx <= image_in_index;
         end else begin
            img_idx <= img_idx;
         end
         case (px_cls)
            COL_R:   cnt_r <= cnt_r + CNT_W'(1);
            COL_G:   cnt_g <= cnt_g + CNT_W'(1);
            COL_B:   cnt_b <= cnt_b + CNT_W'(1);
            default: cnt_b <= cnt_b;
         endcase
      end else if (do_final) begin
         cnt_r    <= '0;
         cnt_g    <= '0;
         cnt_b    <= '0;
         pend_cls <= fin_cls;
         pend_key <= fin_key;
      end else begin
         pix_cnt <= pix_cnt;
      end
   end

   ise_sort_buf #(
      .DEPTH   (IMAGE_NUM),
      .KEY_W   (CNT_W),
      .IDX_W   (IDX_W),
      .COUNT_W (BUF_CW)
   ) u_sort_buf (
      .clk          (clk),
      .reset        (reset),
      .ins          (do_insert),
      .ins_cls      (pend_cls),
      .ins_key      (pend_key),
      .ins_idx      (img_idx),
      .pop          (do_pop),
      .count        (buf_count),
      .head_nxt_cls (head_nxt_cls),
      .head_nxt_key (head_nxt_key),
      .head_nxt_idx (head_nxt_idx)
   );

   // Registered outputs; the beat fields hold once the output phase ends.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         busy            <= 1'b0;
         out_valid       <= 1'b0;
         color_index     <= 2'd0;
         image_out_index <= '0;
         dom_count       <= '0;
      end else begin
         busy <= (state_nxt != ST_ACCEPT);
         if (state_nxt == ST_OUTPUT) begin
            out_valid       <= 1'b1;
            color_index     <= head_nxt_cls;
            image_out_index <= head_nxt_idx;
            dom_count       <= head_nxt_key;
         end else begin
            out_valid <= 1'b0;
         end
      end
   end

endmodule

// File: doc/ise_sort_param.md
Name: ise_sort_param

Overview:
- Parametrised successor to the fixed 32-image, 128x128 image sorting engine (ISE).
- Accepts a stream of IMAGE_NUM images of IMAGE_SIZE x IMAGE_SIZE RGB pixels and classifies each image by dominant colour.
- Insertion-sorts the classified images and emits them in sorted order once a batch completes, then accepts a new batch.
- Added over the fixed block: parametrised sizes, an explicit input valid, a dominant-count output, and back-to-back batches.

Parameters:
- IMAGE_NUM, 32, images per batch (>=2).
- IMAGE_SIZE, 128, image edge in pixels; PIX_N = IMAGE_SIZE*IMAGE_SIZE pixels per image.
- CH_W, 8, bits per colour channel; pixel width = 3*CH_W.
- IDX_W, $clog2(IMAGE_NUM), image index width.
- CNT_W, $clog2(PIX_N+1), dominant-count width.

Ports:
- clk, input, 1, rising-edge clock.
- reset, input, 1, asynchronous active-low reset.
- in_valid, input, 1, pixel present this cycle.
- image_in_index, input, IDX_W, index of the image the pixel belongs to.
- pixel_in, input, 3*CH_W, {R,G,B}; R in the MSBs.
- busy, output, 1, pixel not accepted this cycle when 1.
- out_valid, output, 1, output beat valid.
- color_index, output, 2, 0=R 1=G 2=B.
- image_out_index, output, IDX_W, sorted image index.
- dom_count, output, CNT_W, dominant-colour pixel count of the output image.

Behaviour:
- Handshake: a pixel is accepted on a rising edge with in_valid=1 and busy=0. Pixels with busy=1 or in_valid=0 are ignored, not buffered.
- Reset (reset=0, any time, including mid-batch or mid-output):
  - busy=0, out_valid=0, color_index=0, image_out_index=0, dom_count=0.
  - All counters and the sort buffer are cleared; state=ACCEPT.
- Pixel class: the channel with the maximum value. Ties resolve R > G > B.
  - Three per-image counters cnt_r, cnt_g, cnt_b, each CNT_W bits.
- Image index: latched from the first accepted pixel of each image. Later pixels' image_in_index is ignored.
- Image end: when the PIX_N-th pixel of the image is accepted.
- States:
  - ACCEPT: busy=0. On the last pixel accepted -> FINAL.
  - FINAL (1 cycle, busy=1):
    - class = argmax(cnt_r, cnt_g, cnt_b), ties R > G > B; key = winning count.
    - Counters clear. -> INSERT.
  - INSERT (1 cycle, busy=1):
    - Parallel-compare insertion of {class, key, index} into a sort buffer of depth IMAGE_NUM; entries at and below the insert slot shift down by one.
    - Order: class ascending; then key descending; then index ascending.
    - -> OUTPUT if IMAGE_NUM images are now stored, else -> ACCEPT.
  - OUTPUT (IMAGE_NUM cycles, busy=1):
    - out_valid=1 on consecutive cycles, head of the buffer first; the buffer shifts up each cycle.
    - After the last beat -> ACCEPT, with the buffer empty and the next batch allowed.
- Latency and rate:
  - Busy is 2 cycles after every image.
  - The first out_valid appears on the cycle after INSERT of the last image.
  - Outputs are registered; color_index, image_out_index and dom_count are held at their last value when out_valid=0.
- Duplicate image_in_index values within a batch are not checked; both entries are sorted, and ties are kept stable by arrival order.
- in_valid low mid-image: the pixel count holds; no timeout.
- dom_count width must hold PIX_N exactly (a solid image).

Decomposition:
- Package ise_pkg: colour enum (COL_R=0, COL_G=1, COL_B=2), the sort-entry struct {class, key, index}, and a function that compares two entries under the ordering rule.
- Sub-module ise_sort_buf (parametrised depth): insertion and shift-out buffer with insert, pop, count and head ports.
- Classifier, counters and FSM live in the top module.

Test Plan:
- Reset and idle: IMAGE_NUM=4, IMAGE_SIZE=4; hold reset=0 for 3 cycles -> all outputs 0; busy=0 after release.
- Single-colour batch: indices 3,1,2,0, all pixels 0xFF0000 -> outputs (0,0,16), (0,1,16), (0,2,16), (0,3,16) on 4 consecutive cycles.
- Mixed classes:
  - Inputs: img0 all blue 0x0000FF; img1 10 red + 6 green; img2 16 green; img3 9 red + 7 blue.
  - Expected output: (R,1,10), (R,3,9), (G,2,16), (B,0,16).
- Ties:
  - Pixel 0x808080 classifies as R.
  - Image with 8 green and 8 blue pixels -> class G, dom_count=8.
- Handshake: random in_valid gaps, plus in_valid held high through busy cycles -> pixels offered while busy=1 are dropped; per-image pixel count stays 16; busy high exactly 2 cycles after each image and 4 cycles during output.
- Back-to-back batches and reset mid-output:
  - Second batch right after the first -> correct independent ordering.
  - reset=0 on output beat 2 -> out_valid=0 immediately; a fresh batch then sorts correctly.
